oam_sprite_eval: RTL and testbench

OAM_SPRITE_EVAL -- requirements
Module: oam_sprite_eval

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/sprite_range_cmp.sv | 18 +
 rtl/oam_sprite_eval.sv | 125 ++++++++++++
 tb/tb_oam_sprite_eval.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU types: sprite-eval FSM states, OAM word field positions, sprite defaults.
package ppu_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } eval_state_e;

   localparam int OAM_X_LSB    = 0;
   localparam int OAM_X_MSB    = 7;
   localparam int OAM_Y_LSB    = 8;
   localparam int OAM_Y_MSB    = 15;
   localparam int OAM_PAT_LSB  = 16;
   localparam int OAM_PAT_MSB  = 23;
   localparam int OAM_ATTR_LSB = 24;
   localparam int OAM_ATTR_MSB = 31;

   localparam int SPR_H_DEF        = 16;
   localparam int MAX_PER_LINE_DEF = 8;
endpackage

// File: rtl/sprite_range_cmp.sv
// Vertical hit test for one OAM object: Y <= line < Y+SPR_H, no wrap, plus row inside sprite.
module sprite_range_cmp
   import ppu_pkg::*;
#(
   parameter int SPR_H = SPR_H_DEF
) (
   input  logic [8:0] line_i,
   input  logic [7:0] y_i,
   output logic       hit_o,
   output logic [3:0] row_o
);
   logic [9:0] diff;

   // One extra bit so line < Y shows up as a borrow instead of wrapping.
   assign diff  = {1'b0, line_i} - {2'b00, y_i};
   assign hit_o = !diff[9] && (diff[8:0] < 9'(SPR_H));
   assign row_o = diff[3:0];
endmodule

// File: rtl/oam_sprite_eval.sv
// Per-scanline OAM scan selecting up to MAX_PER_LINE sprites in index order.
// Define SPR_OVERFLOW_EN to report the overflow flag; otherwise the scan stops silently.
module oam_sprite_eval
   import ppu_pkg::*;
#(
   parameter int NUM_OBJ      = 64,
   parameter int MAX_PER_LINE = MAX_PER_LINE_DEF,
   parameter int SPR_H        = SPR_H_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [8:0]  next_line,
   output logic [5:0]  oam_rd_addr,
   input  logic [31:0] oam_rd_data,
   output logic        sel_valid,
   output logic [2:0]  sel_slot,
   output logic [31:0] sel_entry,
   output logic [3:0]  sel_row,
   output logic        eval_done,
   output logic        busy,
   output logic        overflow
);
   localparam int         CNT_W     = $clog2(MAX_PER_LINE + 1);
   localparam logic [5:0] LAST_ADDR = 6'(NUM_OBJ - 1);

   eval_state_e      state_q;
   logic [5:0]       addr_q;
   logic [8:0]       line_q;
   logic [CNT_W-1:0] count_q;
   logic             ret_q;
   logic             sel_valid_q, eval_done_q;
   logic [2:0]       sel_slot_q;
   logic [31:0]      sel_entry_q;
   logic [3:0]       sel_row_q;
   logic             hit;
   logic [3:0]       row;
   logic             take;
`ifdef SPR_OVERFLOW_EN
   logic             overflow_q;
`endif

   sprite_range_cmp #(.SPR_H(SPR_H)) u_cmp (
      .line_i (line_q),
      .y_i    (oam_rd_data[OAM_Y_MSB:OAM_Y_LSB]),
      .hit_o  (hit),
      .row_o  (row)
   );

   // ret_q marks a cycle whose oam_rd_data answers a read of the current line.
   assign take = ret_q && hit && (state_q == ST_SCAN || state_q == ST_DRAIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         line_q      <= '0;
         count_q     <= '0;
         ret_q       <= 1'b0;
         sel_valid_q <= 1'b0;
         sel_slot_q  <= '0;
         sel_entry_q <= '0;
         sel_row_q   <= '0;
         eval_done_q <= 1'b0;
`ifdef SPR_OVERFLOW_EN
         overflow_q  <= 1'b0;
`endif
      end else begin
         sel_valid_q <= 1'b0;
         eval_done_q <= 1'b0;
         if (line_start) begin
            state_q <= ST_SCAN;
            addr_q  <= '0;
            line_q  <= next_line;
            count_q <= '0;
            ret_q   <= 1'b0;
`ifdef SPR_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
         end else begin
            ret_q <= (state_q == ST_SCAN);
            case (state_q)
               ST_SCAN: begin
                  if (addr_q == LAST_ADDR) state_q <= ST_DRAIN;
                  else                     addr_q  <= addr_q + 6'd1;
               end
               ST_DRAIN: state_q <= ST_DONE;
               ST_DONE: begin
                  eval_done_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
               default: ;
            endcase
            if (take) begin
               if (count_q == CNT_W'(MAX_PER_LINE)) begin
`ifdef SPR_OVERFLOW_EN
                  overflow_q <= 1'b1;
`endif
                  state_q <= ST_DONE;
                  ret_q   <= 1'b0;
               end else begin
                  sel_valid_q <= 1'b1;
                  sel_slot_q  <= 3'(count_q);
                  sel_entry_q <= oam_rd_data;
                  sel_row_q   <= row;
                  count_q     <= count_q + 1'b1;
               end
            end
         end
      end
   end

   assign oam_rd_addr = addr_q;
   assign sel_valid   = sel_valid_q;
   assign sel_slot    = sel_slot_q;
   assign sel_entry   = sel_entry_q;
   assign sel_row     = sel_row_q;
   assign eval_done   = eval_done_q;
   assign busy        = (state_q != ST_IDLE);
`ifdef SPR_OVERFLOW_EN
   assign overflow    = overflow_q;
`else
   assign overflow    = 1'b0;
`endif
endmodule

// File: tb/tb_oam_sprite_eval.sv
// Directed bench for oam_sprite_eval with a per-line selection model and per-cycle compare.
module tb_oam_sprite_eval;
   localparam int NUM_OBJ = 64;
   localparam int MAXL    = 8;
   localparam int SPR_H   = 16;
`ifdef SPR_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        line_start = 1'b0;
   logic [8:0]  next_line = '0;
   logic [5:0]  oam_rd_addr;
   logic [31:0] oam_rd_data;
   logic        sel_valid, eval_done, busy, overflow;
   logic [2:0]  sel_slot;
   logic [31:0] sel_entry;
   logic [3:0]  sel_row;

   oam_sprite_eval #(.NUM_OBJ(NUM_OBJ), .MAX_PER_LINE(MAXL), .SPR_H(SPR_H)) dut (
      .clk(clk), .reset(reset), .line_start(line_start), .next_line(next_line),
      .oam_rd_addr(oam_rd_addr), .oam_rd_data(oam_rd_data),
      .sel_valid(sel_valid), .sel_slot(sel_slot), .sel_entry(sel_entry), .sel_row(sel_row),
      .eval_done(eval_done), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [31:0] oam [NUM_OBJ];
   always @(posedge clk) oam_rd_data <= oam[oam_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected behaviour of one line, relative to the edge that sampled line_start.
   int          t0 = 0, n_exp = 0, done_rel = -1, ovf_rel = -1, stop_rel = -1;
   int          e_rel [MAXL];
   int          e_row [MAXL];
   logic [31:0] e_entry [MAXL];
   bit          chk_en = 1'b0;
   int          mon_sv, mon_ed, mon_first_slot, mon_last_slot, mon_last_row, mon_done_rel;

   task automatic mon_clear();
      mon_sv = 0; mon_ed = 0; mon_first_slot = -1; mon_last_slot = -1;
      mon_last_row = -1; mon_done_rel = -1;
   endtask

   task automatic model_line(input int line);
      int  y;
      bit  stop;
      n_exp = 0; ovf_rel = -1; done_rel = NUM_OBJ + 2; stop_rel = NUM_OBJ - 1; stop = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         y = int'(oam[i][15:8]);
         if (!stop && line >= y && line < y + SPR_H) begin
            if (n_exp < MAXL) begin
               e_rel[n_exp]   = i + 2;
               e_row[n_exp]   = line - y;
               e_entry[n_exp] = oam[i];
               n_exp++;
            end else begin
               if (OVF_EN) ovf_rel = i + 2;
               stop_rel = i + 2;
               done_rel = i + 3;
               stop     = 1'b1;
            end
         end
      end
   endtask

   task automatic model_idle();
      t0 = cyc; n_exp = 0; done_rel = -1; ovf_rel = -1; stop_rel = -1;
   endtask

   always @(negedge clk) begin
      int rel, k;
      bit xsv;
      if (chk_en) begin
         rel = cyc - t0;
         if (rel >= 0) begin
            xsv = 1'b0; k = 0;
            for (int j = 0; j < n_exp; j++)
               if (e_rel[j] == rel) begin xsv = 1'b1; k = j; end
            chk("sel_valid", 32'(sel_valid), 32'(xsv));
            if (xsv) begin
               chk("sel_slot", 32'(sel_slot), 32'(k));
               chk("sel_entry", sel_entry, e_entry[k]);
               chk("sel_row", 32'(sel_row), 32'(e_row[k]));
            end
            chk("eval_done", 32'(eval_done), 32'(rel == done_rel));
            chk("busy", 32'(busy), 32'(rel < done_rel));
            chk("overflow", 32'(overflow), 32'(ovf_rel >= 0 && rel >= ovf_rel));
            if (rel <= stop_rel) chk("oam_rd_addr", 32'(oam_rd_addr), 32'(rel));
            if (sel_valid) begin
               if (mon_sv == 0) mon_first_slot = int'(sel_slot);
               mon_sv++;
               mon_last_slot = int'(sel_slot);
               mon_last_row  = int'(sel_row);
            end
            if (eval_done) begin
               mon_ed++;
               mon_done_rel = rel;
            end
         end
      end
   end

   task automatic fill(input logic [7:0] y);
      for (int i = 0; i < NUM_OBJ; i++)
         oam[i] = {8'(i ^ 8'h5A), 8'(i + 3), y, 8'(i * 3)};
   endtask

   task automatic start_line(input int line);
      @(posedge clk); #2;
      line_start = 1'b1;
      next_line  = 9'(line);
      model_line(line);
      t0 = cyc + 1;
      mon_clear();
      @(posedge clk); #2;
      line_start = 1'b0;
   endtask

   task automatic run_line(input int line);
      start_line(line);
      repeat (72) @(posedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(oam_rd_addr), 0);
      chk({tag, "_sv"}, 32'(sel_valid), 0);
      chk({tag, "_slot"}, 32'(sel_slot), 0);
      chk({tag, "_entry"}, sel_entry, 0);
      chk({tag, "_row"}, 32'(sel_row), 0);
      chk({tag, "_done"}, 32'(eval_done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
   endtask

   initial begin
      mon_clear();
      fill(8'd250);
      repeat (3) @(posedge clk);
      #1 chk_zero("rst");
      @(posedge clk); #2;
      reset = 1'b1;
      model_idle();
      chk_en = 1'b1;
      repeat (5) @(posedge clk);

      // Single hit in the middle of OAM
      fill(8'd250);
      oam[5][15:8] = 8'd100;
      run_line(107);
      chk("t1_nsel", 32'(mon_sv), 1);
      chk("t1_slot", 32'(mon_first_slot), 0);
      chk("t1_row", 32'(mon_last_row), 7);
      chk("t1_done_rel", 32'(mon_done_rel), 66);

      // Ten hits: eight selected, early stop on the ninth
      for (int i = 0; i < 10; i++) oam[i][15:8] = 8'd50;
      run_line(50);
      chk("t2_nsel", 32'(mon_sv), 8);
      chk("t2_last_slot", 32'(mon_last_slot), 7);
      chk("t2_done_rel", 32'(mon_done_rel), 11);
      chk("t2_ovf", 32'(overflow), 32'(OVF_EN));

      // Vertical boundaries, no 9-bit wrap
      fill(8'd0);
      oam[3][15:8] = 8'd255;
      run_line(239);
      chk("t3_y255_l239", 32'(mon_sv), 0);
      run_line(270);
      chk("t3_y255_l270", 32'(mon_sv), 1);
      chk("t3_y255_row", 32'(mon_last_row), 15);
      run_line(271);
      chk("t3_y255_l271", 32'(mon_sv), 0);
      oam[3][15:8] = 8'd224;
      run_line(239);
      chk("t3_y224_l239", 32'(mon_sv), 1);
      chk("t3_y224_row", 32'(mon_last_row), 15);
      run_line(240);
      chk("t3_y224_l240", 32'(mon_sv), 0);

      // Scattered hits including the last object
      fill(8'd0);
      oam[2][15:8]  = 8'd110;
      oam[10][15:8] = 8'd105;
      oam[40][15:8] = 8'd104;
      oam[41][15:8] = 8'd121;
      oam[63][15:8] = 8'd120;
      run_line(120);
      chk("t4_nsel", 32'(mon_sv), 3);
      chk("t4_last_slot", 32'(mon_last_slot), 2);
      chk("t4_last_row", 32'(mon_last_row), 0);
      chk("t4_done_rel", 32'(mon_done_rel), 66);

      // Restart 20 cycles into a scan
      start_line(120);
      repeat (18) @(posedge clk);
      run_line(120);
      chk("t5_ndone", 32'(mon_ed), 1);
      chk("t5_first_slot", 32'(mon_first_slot), 0);
      chk("t5_nsel", 32'(mon_sv), 3);
      chk("t5_done_rel", 32'(mon_done_rel), 66);

      // Reset at cycle 30 of a scan
      fill(8'd250);
      oam[5][15:8] = 8'd100;
      start_line(107);
      repeat (29) @(posedge clk); #3;
      chk_en = 1'b0;
      reset  = 1'b0;
      #1 chk_zero("mid_rst");
      repeat (3) @(posedge clk); #2;
      reset = 1'b1;
      model_idle();
      mon_clear();
      chk_en = 1'b1;
      repeat (10) @(posedge clk);
      chk("t6_idle_sel", 32'(mon_sv), 0);
      chk("t6_idle_done", 32'(mon_ed), 0);
      run_line(107);
      chk("t6_nsel", 32'(mon_sv), 1);
      chk("t6_row", 32'(mon_last_row), 7);
      chk("t6_done_rel", 32'(mon_done_rel), 66);

      @(posedge clk); #2;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
